// File: rtl/mem_access_unit_if.sv
// Data-cache port of the memory-stage access unit: held request, one-cycle response pulse.
interface mem_access_unit_if;
   logic        data_read;
   logic        data_write;
   logic [3:0]  data_mbe;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_resp;

   modport master (
      output data_read, data_write, data_mbe, data_addr, data_wdata,
      input  data_rdata, data_resp
   );

   modport slave (
      input  data_read, data_write, data_mbe, data_addr, data_wdata,
      output data_rdata, data_resp
   );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I MEM-stage load/store initiator: issues a held cache request and stalls until it completes.
// Define MEM_MISALIGN_TRAP_EN to complete misaligned half/word accesses without a cache request.
//
// state | meaning
// IDLE  | waiting for a load/store in MEM
// BUSY  | cache request held until data_resp or watchdog expiry
// DONE  | result presented to MEM/WB until advance
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data_in,
   input  logic        advance,
   mem_access_unit_if.master dbus,
   output logic        stall,
   output logic        access_done,
   output logic [3:0]  mem_byte_enable_out,
   output logic [31:0] r_data_out,
   output logic [31:0] w_data_out,
   output logic [31:0] data_addr_out,
   output logic        timeout_err,
   output logic        misaligned
);
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   state_t      state_q, state_d;
   size_t       acc_size;
   logic        accept;
   logic        misalign_hit;
   logic        wdog_expire;
   logic [1:0]  off;
   logic [3:0]  mask_d;
   logic [31:0] wdata_d;
   logic        load_q;
   logic [3:0]  mask_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] r_data_q;
   logic [CW-1:0] wdog_q;
   logic        timeout_err_q;

   assign off    = addr_in[1:0];
   assign accept = req_valid && (is_load || is_store);

   // A load with both flags set decodes as a load; unlisted funct3 values fall back to word.
   always_comb begin
      acc_size = SZ_WORD;
      if (is_load) begin
         if (funct3 == 3'b000 || funct3 == 3'b100)      acc_size = SZ_BYTE;
         else if (funct3 == 3'b001 || funct3 == 3'b101) acc_size = SZ_HALF;
      end else begin
         if (funct3 == 3'b000)      acc_size = SZ_BYTE;
         else if (funct3 == 3'b001) acc_size = SZ_HALF;
      end
   end

   always_comb begin
      mask_d  = 4'b1111;
      wdata_d = store_data_in;
      case (acc_size)
         SZ_BYTE: begin
            mask_d  = 4'b0001 << off;
            wdata_d = {24'b0, store_data_in[7:0]} << {off, 3'b000};
         end
         SZ_HALF: begin
            mask_d  = 4'b0011 << off;
            wdata_d = {16'b0, store_data_in[15:0]} << {off, 3'b000};
         end
         default: ;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned_q;
   assign misalign_hit = ((acc_size == SZ_HALF) && off[0]) ||
                         ((acc_size == SZ_WORD) && (off != 2'b00));
   assign misaligned   = misaligned_q;

   always_ff @(posedge clk) begin
      if (rst)                                misaligned_q <= 1'b0;
      else if (state_q == S_IDLE && accept)   misaligned_q <= misalign_hit;
      else if (state_q == S_DONE && advance)  misaligned_q <= 1'b0;
   end
`else
   assign misalign_hit = 1'b0;
   assign misaligned   = 1'b0;
`endif

   assign wdog_expire = (TIMEOUT_CYCLES > 0) && (wdog_q == CW'(1));

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         S_IDLE: if (accept) begin
            stall   = 1'b1;
            state_d = misalign_hit ? S_DONE : S_BUSY;
         end
         S_BUSY: begin
            stall = 1'b1;
            if (dbus.data_resp || wdog_expire) state_d = S_DONE;
         end
         S_DONE: if (advance) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         load_q        <= 1'b0;
         mask_q        <= 4'b0;
         addr_q        <= 32'b0;
         wdata_q       <= 32'b0;
         r_data_q      <= 32'b0;
         wdog_q        <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (accept) begin
               load_q   <= is_load;
               mask_q   <= misalign_hit ? 4'b0 : mask_d;
               addr_q   <= addr_in;
               wdata_q  <= wdata_d;
               r_data_q <= 32'b0;
               wdog_q   <= CW'(TIMEOUT_CYCLES);
            end
            S_BUSY: begin
               // A response in the expiry cycle still completes normally.
               if (dbus.data_resp) begin
                  r_data_q <= load_q ? dbus.data_rdata : 32'b0;
               end else if (wdog_expire) begin
                  r_data_q      <= 32'b0;
                  timeout_err_q <= 1'b1;
               end else begin
                  wdog_q <= wdog_q - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign dbus.data_read       = (state_q == S_BUSY) &&  load_q;
   assign dbus.data_write      = (state_q == S_BUSY) && !load_q;
   assign dbus.data_mbe        = mask_q;
   assign dbus.data_addr       = {addr_q[31:2], 2'b00};
   assign dbus.data_wdata      = wdata_q;
   assign access_done          = (state_q == S_DONE);
   assign mem_byte_enable_out  = mask_q;
   assign r_data_out           = r_data_q;
   assign w_data_out           = wdata_q;
   assign data_addr_out        = addr_q;
   assign timeout_err          = timeout_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: lane-level reference model, queued expectations, negedge monitors.
module tb_mem_access_unit;
   localparam int TMO = 8;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, is_load, is_store, advance;
   logic [2:0]  funct3;
   logic [31:0] addr_in, store_data_in;
   logic        stall, access_done, timeout_err, misaligned;
   logic [3:0]  mem_byte_enable_out;
   logic [31:0] r_data_out, w_data_out, data_addr_out;

   mem_access_unit_if bus();

   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .addr_in(addr_in), .store_data_in(store_data_in), .advance(advance),
      .dbus(bus), .stall(stall), .access_done(access_done),
      .mem_byte_enable_out(mem_byte_enable_out), .r_data_out(r_data_out),
      .w_data_out(w_data_out), .data_addr_out(data_addr_out),
      .timeout_err(timeout_err), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rd; bit wr; logic [3:0] mbe; logic [31:0] addr; logic [31:0] wdata; bit chk_wdata; int held;
   } req_t;
   typedef struct {
      logic [3:0] mbe; logic [31:0] rdata; logic [31:0] wdata; bit chk_wdata;
      logic [31:0] addr; bit terr; bit mis;
   } res_t;

   req_t req_q[$];
   res_t res_q[$];
   int   stall_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   terr_model = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic int size_of(input bit ld, input logic [2:0] f3);
      if (ld) begin
         if (f3 == 3'd0 || f3 == 3'd4) return 1;
         if (f3 == 3'd1 || f3 == 3'd5) return 2;
         return 4;
      end
      if (f3 == 3'd0) return 1;
      if (f3 == 3'd1) return 2;
      return 4;
   endfunction

   // Byte lane b is touched when off <= b < off+size, clipped at the top of the word.
   function automatic logic [3:0] lane_mask(input int sz, input int o);
      logic [3:0] m;
      m = 4'b0;
      for (int b = 0; b < 4; b++) if (sz == 4 || (b >= o && b < o + sz)) m[b] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] lane_data(input int sz, input int o, input logic [31:0] sd);
      logic [31:0] d;
      if (sz == 4) return sd;
      d = 32'b0;
      for (int b = 0; b < 4; b++) if (b >= o && b < o + sz) d[8*b +: 8] = sd[8*(b-o) +: 8];
      return d;
   endfunction

   // delay: BUSY cycle (1-based) carrying data_resp; 0 means the cache never answers.
   task automatic access(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int delay, input logic [31:0] rd_word);
      req_t rq;
      res_t rs;
      int   sz, o, busy, n;
      bit   load, mis, timed;
      load  = ld;
      sz    = size_of(load, f3);
      o     = int'(a[1:0]);
      mis   = TRAP && (sz > 1) && ((o % sz) != 0);
      timed = (delay == 0) || (delay > TMO);
      busy  = timed ? TMO : delay;
      if (!mis) begin
         rq.rd = load; rq.wr = !load; rq.mbe = lane_mask(sz, o); rq.addr = {a[31:2], 2'b00};
         rq.wdata = lane_data(sz, o, sd); rq.chk_wdata = !load; rq.held = busy;
         req_q.push_back(rq);
         if (timed) terr_model = 1'b1;
      end
      rs.mbe = mis ? 4'b0 : lane_mask(sz, o);
      rs.rdata = (mis || timed || !load) ? 32'b0 : rd_word;
      rs.wdata = lane_data(sz, o, sd);
      rs.chk_wdata = !load && !mis;
      rs.addr = a;
      rs.terr = terr_model;
      rs.mis = mis;
      res_q.push_back(rs);
      stall_q.push_back(mis ? 1 : 1 + busy);

      req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr_in = a; store_data_in = sd;
      @(posedge clk); #1;
      req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; addr_in = $urandom; store_data_in = $urandom;
      if (!mis && !timed) begin
         repeat (delay - 1) begin @(posedge clk); #1; end
         bus.data_resp = 1'b1; bus.data_rdata = rd_word;
         @(posedge clk); #1;
         bus.data_resp = 1'b0; bus.data_rdata = $urandom;
      end
      n = 0;
      while (!access_done && n < TMO + 20) begin @(posedge clk); #1; n++; end
      chk("done_seen", access_done, 1'b1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      advance = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
         req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr_in = $urandom;
      end
      @(posedge clk); #1;
      advance = 1'b0; req_valid = 1'b0; is_load = 1'b0;
   endtask

   // Request monitor: fields checked every held cycle, hold length checked at drop.
   req_t cur_req;
   bit   have_req = 1'b0, req_prev = 1'b0;
   int   held = 0;
   always @(negedge clk) begin
      if (bus.data_read || bus.data_write) begin
         if (!req_prev) begin
            if (req_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_request: actual=1 required=0");
               have_req = 1'b0;
            end else begin
               cur_req = req_q.pop_front(); have_req = 1'b1; held = 0;
            end
         end
         if (have_req) begin
            held++;
            chk("data_read", bus.data_read, cur_req.rd);
            chk("data_write", bus.data_write, cur_req.wr);
            chk("data_mbe", bus.data_mbe, cur_req.mbe);
            chk("data_addr", bus.data_addr, cur_req.addr);
            if (cur_req.chk_wdata) chk("data_wdata", bus.data_wdata, cur_req.wdata);
         end
      end else if (req_prev && have_req) begin
         chk("req_held_cycles", held, cur_req.held);
         have_req = 1'b0;
      end
      req_prev = bus.data_read || bus.data_write;
   end

   res_t cur_res;
   bit   done_prev = 1'b0;
   always @(negedge clk) begin
      if (access_done && !done_prev) begin
         if (res_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_done: actual=1 required=0");
         end else begin
            cur_res = res_q.pop_front();
            chk("mbe_out", mem_byte_enable_out, cur_res.mbe);
            chk("r_data_out", r_data_out, cur_res.rdata);
            if (cur_res.chk_wdata) chk("w_data_out", w_data_out, cur_res.wdata);
            chk("data_addr_out", data_addr_out, cur_res.addr);
            chk("timeout_err", timeout_err, cur_res.terr);
            chk("misaligned", misaligned, cur_res.mis);
         end
      end
      done_prev = access_done;
   end

   int stall_run = 0;
   always @(negedge clk) begin
      if (stall) stall_run++;
      else if (stall_run > 0) begin
         if (stall_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_stall: actual=%0d required=0", stall_run);
         end else chk("stall_cycles", stall_run, stall_q.pop_front());
         stall_run = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; advance = 1'b0;
      funct3 = 3'b0; addr_in = 32'b0; store_data_in = 32'b0;
      bus.data_resp = 1'b0; bus.data_rdata = 32'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_done", access_done, 1'b0);
      chk("rst_read_write", {bus.data_read, bus.data_write}, 2'b00);
      chk("rst_mbe", bus.data_mbe, 4'b0);
      chk("rst_addr", bus.data_addr, 32'b0);
      chk("rst_wdata", bus.data_wdata, 32'b0);
      chk("rst_results", {mem_byte_enable_out, r_data_out, w_data_out, data_addr_out} == '0, 1'b1);
      chk("rst_flags", {timeout_err, misaligned}, 2'b00);
      rst = 1'b0;
      @(posedge clk); #1;

      req_valid = 1'b1; funct3 = 3'b010; addr_in = 32'h77;
      #1 chk("neither_stall", stall, 1'b0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("neither_idle", {access_done, bus.data_read, bus.data_write}, 3'b000);

      access(1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h0);
      access(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 2, 32'h0);
      access(1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'h0, 5, 32'h1234_ABCD);
      access(1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0, 1, 32'hCAFE_F00D);
      access(1'b1, 1'b0, 3'b001, 32'h0000_6003, 32'h0, 2, 32'h5566_7788);
      access(1'b1, 1'b1, 3'b000, 32'h0000_6001, 32'h0, 3, 32'h0BAD_F00D);

      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = $urandom_range(0, 2);
         access(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(1, TMO), $urandom);
      end

      access(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, TMO, 32'h1357_9BDF);
      access(1'b0, 1'b1, 3'b010, 32'h0000_8008, 32'h1122_3344, 0, 32'h0);
      for (int i = 0; i < 3; i++)
         access(1'b1, 1'b0, 3'b010, {$urandom_range(0, 65535), 16'h0}, 32'h0,
                $urandom_range(1, TMO), $urandom);

      begin
         req_t rq;
         rq.rd = 1'b1; rq.wr = 1'b0; rq.mbe = 4'hF; rq.addr = 32'h5000;
         rq.wdata = 32'h0; rq.chk_wdata = 1'b0; rq.held = 2;
         req_q.push_back(rq);
         stall_q.push_back(3);
      end
      req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr_in = 32'h5000;
      @(posedge clk); #1;
      req_valid = 1'b0; is_load = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; terr_model = 1'b0;
      chk("rst_busy_read_dropped", bus.data_read, 1'b0);
      chk("rst_busy_stall", stall, 1'b0);
      bus.data_resp = 1'b1; bus.data_rdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      bus.data_resp = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("late_resp_no_done", access_done, 1'b0);
         chk("late_resp_no_read", bus.data_read, 1'b0);
      end
      chk("rst_clears_timeout_err", timeout_err, 1'b0);

      access(1'b0, 1'b1, 3'b001, 32'h0000_9002, 32'h0000_BEEF, 1, 32'h0);
      repeat (3) @(posedge clk);
      #1 chk("queues_drained", req_q.size() + res_q.size() + stall_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store initiator for the pipelined RV32I core.
- Turns a load/store in MEM into a held-request/response transaction on the data-cache port. Generates byte enables and lane-shifted store data, and captures the raw read word.
- Stalls the pipeline until the access completes, then presents mem_byte_enable, r_data, w_data and data_addr for the MEM/WB latch; write-back does the lane extraction.

Parameters:
TIMEOUT_CYCLES, 0, max cycles in BUSY before abandoning a request; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  instruction in MEM is valid
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store
funct3  in  3  RV32I load/store funct3
addr_in  in  32  effective address from ALU
store_data_in  in  32  rs2 value
advance  in  1  pipeline advancing MEM->WB this cycle
data_rdata  in  32  cache read word
data_resp  in  1  cache response, one-cycle pulse
data_read  out  1  cache read request
data_write  out  1  cache write request
data_mbe  out  4  cache byte enables
data_addr  out  32  word-aligned cache address
data_wdata  out  32  lane-shifted store data
stall  out  1  hold upstream pipeline
access_done  out  1  completed result valid (state DONE)
mem_byte_enable_out  out  4  byte mask of the completed access
r_data_out  out  32  raw captured read word
w_data_out  out  32  issued store word
data_addr_out  out  32  full unaligned effective address
timeout_err  out  1  sticky watchdog error
misaligned  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, watchdog count 0, timeout_err cleared.
- Reset mid-BUSY drops data_read/data_write at that edge. A data_resp arriving later in IDLE is ignored.
- Mask: off = addr_in[1:0].
  - Byte: 4'b0001<<off.
  - Half: (4'b0011<<off) truncated to 4 bits, so off=3 gives 4'b1000.
  - Word: 4'b1111.
- Store data: byte is store_data_in[7:0]<<(8*off); half is store_data_in[15:0]<<(8*off), truncated to 32 bits; word is unshifted.
- data_addr = {addr_in[31:2],2'b00}.
- Load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Store funct3: 000, 001, 010. Other funct3 values are treated as word.
- FSM IDLE:
  - On req_valid with is_load or is_store, latch mask, address and wdata, then go BUSY.
  - If both is_load and is_store are set, the access is a load.
  - req_valid with neither set: stay IDLE, stall=0.
- FSM BUSY:
  - data_read (load) or data_write (store) is held high with data_mbe, data_addr and data_wdata stable until data_resp.
  - On data_resp: capture data_rdata (loads) into r_data_out, drop the request at the same edge, go DONE.
- FSM DONE:
  - access_done=1 and result outputs held.
  - advance=1 returns to IDLE; no new acceptance in that cycle.
- stall: 1 in the IDLE accept cycle and throughout BUSY (including the data_resp cycle); 0 in IDLE otherwise and in DONE.
- Latency: accept at T0, request visible T1, resp at Tk, access_done at Tk+1. Zero-wait cache: stall high 2 cycles.
- Watchdog (TIMEOUT_CYCLES>0):
  - Count BUSY cycles. When the count equals TIMEOUT_CYCLES, drop the request, set timeout_err (sticky until rst), and go DONE with r_data_out=0.
  - A data_resp coinciding with the timeout cycle wins; no error is raised.
- Store completion: r_data_out=0. w_data_out = issued data_wdata. mem_byte_enable_out = issued mask.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - Misaligned accesses are lh/lhu/sh with addr_in[0]=1, or lw/sw with addr_in[1:0]!=0.
  - These issue no cache request. IDLE goes directly to DONE next cycle with misaligned=1, mem_byte_enable_out=0 and r_data_out=0.
  - stall is 1 for the accept cycle only. misaligned clears on leaving DONE.
- Undefined: misaligned tied 0. The access is issued with the truncated mask (e.g. lh at off=3 gives 4'b1000).

Test Plan:
- sw addr 0x1004, rs2 0xDEADBEEF, resp on 1st BUSY cycle -> data_write=1, data_addr=0x1004, mbe 4'b1111, wdata 0xDEADBEEF; stall high 2 cycles; access_done next.
- sb addr 0x2003, rs2 0x000000A5 -> mbe 4'b1000, data_wdata 0xA5000000, data_addr 0x2000.
- lhu addr 0x3002, resp after 5 cycles with rdata 0x1234ABCD -> data_read held stable 5 cycles, r_data_out 0x1234ABCD, mbe_out 4'b1100.
- TIMEOUT_CYCLES=4, no resp -> request dropped after 4 BUSY cycles, timeout_err=1 until rst, access_done=1.
- rst asserted in BUSY, then a late data_resp -> data_read=0 after the reset edge, state IDLE, no access_done.
- lw addr 0x4001 with MEM_MISALIGN_TRAP_EN -> no data_read, misaligned=1, stall 1 cycle. Without the macro -> data_read with mbe 4'b1111.
